// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - multi-cycle 8-bit ALU with serial shifter and a registered register-file write port
// Shifts take one cycle per bit position; all other ops finish in a single cycle.
module alu_exec #(
    parameter int pw = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [7:0]    inA,
    input  logic [7:0]    inB,
    input  logic [pw-1:0] dstAddr,
    input  logic          scryIn,
    output logic [7:0]    result,
    output logic [pw-1:0] writeAddr,
    output logic          writeEnable,
    output logic          scryOut,
    output logic          ngtvOut,
    output logic          zeroOut,
    output logic          busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    typedef enum logic [1:0] {IDLE, SHIFT, WB} state_t;

    state_t          state_q;
    logic [2:0]      count_q;
    logic [7:0]      work_q;
    logic            dir_right_q;
    logic [pw-1:0]   dst_q;
    logic [7:0]      result_q;
    logic [pw-1:0]   waddr_q;
    logic            we_q;
    logic            busy_q;
    logic            scry_q;
    logic            ngtv_q;
    logic            zero_q;

    logic [8:0]      sum9;
    logic [7:0]      alu_res;
    logic            alu_c;
    logic [7:0]      shift_val;
    logic            shift_c;
    logic [7:0]      wr_res_d;
    logic            wr_c_d;
    logic            is_shift;

    assign is_shift = (op == OP_SHL) || (op == OP_SHR);

    // Single-cycle ops; shift-by-0 falls through to the default and returns inA.
    always_comb begin
        sum9    = 9'd0;
        alu_res = inA;
        alu_c   = scryIn;
        case (op)
            OP_ADD: begin
                sum9    = {1'b0, inA} + {1'b0, inB};
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
            end
            OP_SUB: begin
                sum9    = {1'b0, inA} - {1'b0, inB};
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
            end
            OP_AND:  alu_res = inA & inB;
            OP_OR:   alu_res = inA | inB;
            OP_XOR:  alu_res = inA ^ inB;
            OP_MOV:  alu_res = inB;
            default: alu_res = inA;
        endcase
    end

    always_comb begin
        shift_val = dir_right_q ? {1'b0, work_q[7:1]} : {work_q[6:0], 1'b0};
        shift_c   = dir_right_q ? work_q[0] : work_q[7];
        wr_res_d  = (state_q == SHIFT) ? shift_val : alu_res;
        wr_c_d    = (state_q == SHIFT) ? shift_c   : alu_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= 3'd0;
            work_q      <= 8'h00;
            dir_right_q <= 1'b0;
            dst_q       <= '0;
            result_q    <= 8'h00;
            waddr_q     <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            scry_q      <= 1'b0;
            ngtv_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q      <= 1'b1;
                        dst_q       <= dstAddr;
                        work_q      <= inA;
                        dir_right_q <= (op == OP_SHR);
                        if (is_shift && (inB[2:0] != 3'd0)) begin
                            count_q <= inB[2:0];
                            state_q <= SHIFT;
                        end else begin
                            state_q  <= WB;
                            we_q     <= 1'b1;
                            result_q <= wr_res_d;
                            waddr_q  <= dstAddr;
                            scry_q   <= wr_c_d;
                            ngtv_q   <= wr_res_d[7];
                            zero_q   <= (wr_res_d == 8'h00);
                        end
                    end
                end
                SHIFT: begin
                    work_q  <= shift_val;
                    count_q <= count_q - 3'd1;
                    // Last shift lands directly in the write registers so WB needs no extra cycle.
                    if (count_q == 3'd1) begin
                        state_q  <= WB;
                        we_q     <= 1'b1;
                        result_q <= wr_res_d;
                        waddr_q  <= dst_q;
                        scry_q   <= wr_c_d;
                        ngtv_q   <= wr_res_d[7];
                        zero_q   <= (wr_res_d == 8'h00);
                    end
                end
                WB: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result      = result_q;
    assign writeAddr   = waddr_q;
    assign writeEnable = we_q;
    assign scryOut     = scry_q;
    assign ngtvOut     = ngtv_q;
    assign zeroOut     = zero_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed self-checking bench for alu_exec
module tb_alu_exec;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] inA;
    logic [7:0] inB;
    logic [2:0] dstAddr;
    logic       scryIn;
    logic [7:0] result;
    logic [2:0] writeAddr;
    logic       writeEnable;
    logic       scryOut;
    logic       ngtvOut;
    logic       zeroOut;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int lat;

    alu_exec #(.pw(3)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
        .dstAddr(dstAddr), .scryIn(scryIn), .result(result), .writeAddr(writeAddr),
        .writeEnable(writeEnable), .scryOut(scryOut), .ngtvOut(ngtvOut),
        .zeroOut(zeroOut), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse through the start edge; lat counts edges from that edge on.
    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] d, input logic c);
        op = o; inA = a; inB = b; dstAddr = d; scryIn = c; start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
    endtask

    task automatic wait_we();
        while (writeEnable !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] d, input logic c,
                       input int exp_lat, input logic [7:0] exp_res, input logic exp_c,
                       input logic exp_n, input logic exp_z);
        issue(o, a, b, d, c);
        wait_we();
        chk({tag, "_lat"},  lat, exp_lat);
        chk({tag, "_res"},  result, exp_res);
        chk({tag, "_addr"}, writeAddr, d);
        chk({tag, "_scry"}, scryOut, exp_c);
        chk({tag, "_ngtv"}, ngtvOut, exp_n);
        chk({tag, "_zero"}, zeroOut, exp_z);
        step();
        chk({tag, "_we_off"}, writeEnable, 1'b0);
        chk({tag, "_idle"},   busy, 1'b0);
        chk({tag, "_hold"},   result, exp_res);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; inA = 8'h00; inB = 8'h00;
        dstAddr = 3'd0; scryIn = 1'b0;
        #3;
        chk("rst_outs", {result, writeAddr, writeEnable, scryOut, ngtvOut, zeroOut, busy}, 32'd0);
        step();
        step();
        reset = 1'b1;

        run("add_7f_01", 3'b000, 8'h7F, 8'h01, 3'd3, 1'b0, 1, 8'h80, 1'b0, 1'b1, 1'b0);
        run("add_carry", 3'b000, 8'hFF, 8'h02, 3'd1, 1'b0, 1, 8'h01, 1'b1, 1'b0, 1'b0);
        run("sub_5_5",   3'b001, 8'h05, 8'h05, 3'd2, 1'b1, 1, 8'h00, 1'b0, 1'b0, 1'b1);
        run("sub_3_4",   3'b001, 8'h03, 8'h04, 3'd4, 1'b0, 1, 8'hFF, 1'b1, 1'b1, 1'b0);
        run("shr_81_1",  3'b110, 8'h81, 8'h01, 3'd5, 1'b0, 2, 8'h40, 1'b1, 1'b0, 1'b0);
        run("shl_81_3",  3'b101, 8'h81, 8'h03, 3'd6, 1'b1, 4, 8'h08, 1'b0, 1'b0, 1'b0);
        run("xor_aa",    3'b100, 8'hAA, 8'hAA, 3'd7, 1'b1, 1, 8'h00, 1'b1, 1'b0, 1'b1);
        run("and_f0_3c", 3'b010, 8'hF0, 8'h3C, 3'd1, 1'b0, 1, 8'h30, 1'b0, 1'b0, 1'b0);
        run("or_0f_80",  3'b011, 8'h0F, 8'h80, 3'd2, 1'b1, 1, 8'h8F, 1'b1, 1'b1, 1'b0);
        run("mov_b",     3'b111, 8'h12, 8'h00, 3'd3, 1'b0, 1, 8'h00, 1'b0, 1'b0, 1'b1);
        run("shl_by0",   3'b101, 8'h55, 8'h08, 3'd4, 1'b1, 1, 8'h55, 1'b1, 1'b0, 1'b0);
        run("shr_07",    3'b110, 8'hF0, 8'h07, 3'd5, 1'b0, 8, 8'h01, 1'b1, 1'b0, 1'b0);

        // SHL-by-7 with a competing start while busy.
        issue(3'b101, 8'h03, 8'h07, 3'd5, 1'b0);
        step(); lat++;
        step(); lat++;
        chk("busy_mid", {busy, writeEnable}, 2'b10);
        op = 3'b000; inA = 8'h01; inB = 8'h01; dstAddr = 3'd2; scryIn = 1'b1; start = 1'b1;
        step(); lat++;
        start = 1'b0;
        wait_we();
        chk("busy_lat",  lat, 8);
        chk("busy_res",  result, 8'h80);
        chk("busy_addr", writeAddr, 3'd5);
        chk("busy_flag", {scryOut, ngtvOut, zeroOut}, 3'b110);
        step();
        chk("busy_done", {busy, writeEnable}, 2'b00);
        step();
        chk("busy_nosecond", {busy, writeEnable}, 2'b00);

        // Start held during the WB cycle is dropped.
        issue(3'b000, 8'h10, 8'h20, 3'd1, 1'b0);
        chk("wb_we", writeEnable, 1'b1);
        op = 3'b111; inB = 8'hEE; dstAddr = 3'd6; start = 1'b1;
        step();
        start = 1'b0;
        chk("wb_ign_busy", {busy, writeEnable}, 2'b00);
        step();
        chk("wb_ign_we", {busy, writeEnable}, 2'b00);
        chk("wb_ign_res", result, 8'h30);

        // Reset mid-SHIFT aborts with no strobe.
        issue(3'b101, 8'h01, 8'h05, 3'd3, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("rst_mid_outs", {result, writeAddr, writeEnable, scryOut, ngtvOut, zeroOut, busy}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_hold_we", writeEnable, 1'b0);
        end
        reset = 1'b1;
        run("post_rst_add", 3'b000, 8'h01, 8'h01, 3'd2, 1'b0, 1, 8'h02, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
